// File: rtl/axi_revision_fetch_pkg.sv
// ---------------------------------------------------------------------------
// axi_revision_fetch_pkg
// Shared definitions for the revision-word fetch master: FSM state encoding,
// AXI read-response codes and the register index map.  The revision-register
// slave uses the same index map, so both sides agree on word order.
// ---------------------------------------------------------------------------
package axi_revision_fetch_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ADDR   = 3'd1,
      ST_DATA   = 3'd2,
      ST_COMMIT = 3'd3,
      ST_FAIL   = 3'd4
   } fetch_state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [2:0] IDX_MAJOR = 3'd0;
   localparam logic [2:0] IDX_MINOR = 3'd1;
   localparam logic [2:0] IDX_BUILD = 3'd2;
   localparam logic [2:0] IDX_RCAND = 3'd3;
   localparam logic [2:0] IDX_DATE  = 3'd4;

   localparam int NUM_REGS = 5;

endpackage

// File: rtl/axi_revision_fetch.sv
// ---------------------------------------------------------------------------
// axi_revision_fetch
// AXI4-Lite read master that fetches the five revision words (major, minor,
// build, release-candidate, date) and presents them as a stable snapshot.
// A snapshot is only committed when all five reads return OKAY; a bad
// response or a per-transaction timeout leaves the previous snapshot intact.
//
// Ports:
//   AXI_ACLK, AXI_ARESETN      clock, asynchronous active-low reset
//   start                      one-cycle fetch request (ignored while busy)
//   busy                       fetch in progress
//   done                       one-cycle pulse on successful commit
//   error, err_index           sticky failure flag and failing register index
//   valid                      at least one snapshot committed
//   rev_major..rev_date        committed snapshot
//   M_AXI_AR*, M_AXI_R*        AXI4-Lite read address / read data channels
// ---------------------------------------------------------------------------
module axi_revision_fetch
   import axi_revision_fetch_pkg::*;
#(
   parameter int M_AXI_ADDR_WIDTH = 5,
   parameter int M_AXI_DATA_WIDTH = 32,
   parameter int BASE_ADDR        = 0,
   parameter bit AUTO_START       = 1'b1,
   parameter int TIMEOUT_CYCLES   = 1024
) (
   input  logic                        AXI_ACLK,
   input  logic                        AXI_ARESETN,
   input  logic                        start,
   output logic                        busy,
   output logic                        done,
   output logic                        error,
   output logic [2:0]                  err_index,
   output logic                        valid,
   output logic [M_AXI_DATA_WIDTH-1:0] rev_major,
   output logic [M_AXI_DATA_WIDTH-1:0] rev_minor,
   output logic [M_AXI_DATA_WIDTH-1:0] rev_build,
   output logic [M_AXI_DATA_WIDTH-1:0] rev_rcand,
   output logic [M_AXI_DATA_WIDTH-1:0] rev_date,
   output logic [M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
   output logic                        M_AXI_ARVALID,
   output logic [2:0]                  M_AXI_ARPROT,
   input  logic                        M_AXI_ARREADY,
   input  logic [M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
   input  logic [1:0]                  M_AXI_RRESP,
   input  logic                        M_AXI_RVALID,
   output logic                        M_AXI_RREADY
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [M_AXI_ADDR_WIDTH-1:0] BASE = M_AXI_ADDR_WIDTH'(BASE_ADDR);

   fetch_state_t                state, state_nxt;
   logic [2:0]                  idx;
   logic                        auto_pend;
   logic [CNT_W-1:0]            tmo_cnt;
   logic                        tmo_hit;
   logic                        launch;    // IDLE -> ADDR for index 0
   logic                        advance;   // DATA -> ADDR for the next index
   logic                        capture;   // OKAY beat, store into shadow
   logic [M_AXI_DATA_WIDTH-1:0] shadow [NUM_REGS];

   function automatic logic [M_AXI_ADDR_WIDTH-1:0] addr_of(input logic [2:0] i);
      return BASE + M_AXI_ADDR_WIDTH'({i, 2'b00});
   endfunction

   assign busy         = (state != ST_IDLE);
   assign M_AXI_ARPROT = 3'b000;
   // Combinational so a beat already waiting is accepted on the first DATA cycle.
   assign M_AXI_RREADY = (state == ST_DATA);
   assign tmo_hit      = (tmo_cnt == TMO_LAST);

   always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
      if (!AXI_ARESETN) state <= ST_IDLE;
      else              state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      launch    = 1'b0;
      advance   = 1'b0;
      capture   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start || auto_pend) begin
               state_nxt = ST_ADDR;
               launch    = 1'b1;
            end
         end
         ST_ADDR: begin
            if (M_AXI_ARREADY)  state_nxt = ST_DATA;
            else if (tmo_hit)   state_nxt = ST_FAIL;
         end
         ST_DATA: begin
            if (M_AXI_RVALID) begin
               if (M_AXI_RRESP == RESP_OKAY) begin
                  capture = 1'b1;
                  if (idx == IDX_DATE) begin
                     state_nxt = ST_COMMIT;
                  end else begin
                     state_nxt = ST_ADDR;
                     advance   = 1'b1;
                  end
               end else begin
                  state_nxt = ST_FAIL;
               end
            end else if (tmo_hit) begin
               state_nxt = ST_FAIL;
            end
         end
         ST_COMMIT: state_nxt = ST_IDLE;
         ST_FAIL:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Control: index, timeout, AR channel, status flags
   always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
      if (!AXI_ARESETN) begin
         auto_pend     <= AUTO_START;
         idx           <= 3'd0;
         tmo_cnt       <= '0;
         M_AXI_ARVALID <= 1'b0;
         M_AXI_ARADDR  <= '0;
         done          <= 1'b0;
         error         <= 1'b0;
         err_index     <= 3'd0;
      end else begin
         // Auto-start only gets the very first cycle after reset.
         auto_pend     <= 1'b0;
         // ARVALID is high exactly in ADDR; this also drops it on timeout.
         M_AXI_ARVALID <= (state_nxt == ST_ADDR);
         done          <= (state == ST_COMMIT);
         if (launch) begin
            idx          <= 3'd0;
            tmo_cnt      <= '0;
            M_AXI_ARADDR <= addr_of(3'd0);
            error        <= 1'b0;
         end else if (advance) begin
            idx          <= 3'(idx + 3'd1);
            tmo_cnt      <= '0;
            M_AXI_ARADDR <= addr_of(3'(idx + 3'd1));
         end else if (state == ST_ADDR || state == ST_DATA) begin
            tmo_cnt <= tmo_cnt + 1'b1;
         end
         if (state == ST_FAIL) begin
            error     <= 1'b1;
            err_index <= idx;
         end
      end
   end

   // Shadow capture: data only, no reset needed
   always_ff @(posedge AXI_ACLK) begin
      if (capture) shadow[idx] <= M_AXI_RDATA;
   end

   // Commit: snapshot becomes visible on the same edge that raises done
   always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
      if (!AXI_ARESETN) begin
         valid     <= 1'b0;
         rev_major <= '0;
         rev_minor <= '0;
         rev_build <= '0;
         rev_rcand <= '0;
         rev_date  <= '0;
      end else if (state == ST_COMMIT) begin
         valid     <= 1'b1;
         rev_major <= shadow[IDX_MAJOR];
         rev_minor <= shadow[IDX_MINOR];
         rev_build <= shadow[IDX_BUILD];
         rev_rcand <= shadow[IDX_RCAND];
         rev_date  <= shadow[IDX_DATE];
      end
   end

endmodule

// File: tb/tb_axi_revision_fetch.sv
// ---------------------------------------------------------------------------
// tb_axi_revision_fetch
// Scoreboard bench: stimulus pushes the expected outcome of each fetch into a
// queue; a monitor pops and compares whenever a fetch finishes (busy falls).
// A configurable AXI4-Lite slave model supplies per-index delays/responses.
// ---------------------------------------------------------------------------
module tb_axi_revision_fetch;
   import axi_revision_fetch_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        busy, done, error, valid;
   logic [2:0]  err_index;
   logic [31:0] rev_major, rev_minor, rev_build, rev_rcand, rev_date;
   logic [4:0]  araddr;
   logic        arvalid, arready;
   logic [2:0]  arprot;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid, rready;

   always #5 clk = ~clk;

   axi_revision_fetch #(
      .M_AXI_ADDR_WIDTH(5), .M_AXI_DATA_WIDTH(32), .BASE_ADDR(0),
      .AUTO_START(1'b1), .TIMEOUT_CYCLES(16)
   ) dut (
      .AXI_ACLK(clk), .AXI_ARESETN(rst_n), .start(start),
      .busy(busy), .done(done), .error(error), .err_index(err_index),
      .valid(valid), .rev_major(rev_major), .rev_minor(rev_minor),
      .rev_build(rev_build), .rev_rcand(rev_rcand), .rev_date(rev_date),
      .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARPROT(arprot),
      .M_AXI_ARREADY(arready), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp),
      .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
   );

   // ---------------- slave model ----------------
   logic [31:0] sdata [8];
   logic [1:0]  sresp [8];
   int          ar_dly [8];   // cycles ARREADY stays low while ARVALID is high
   int          r_dly  [8];   // RVALID appears this many cycles after the AR handshake
   bit          never_ready = 1'b0;
   int          ar_wait;
   logic        s_pend;
   logic [2:0]  s_idx;
   int          r_cnt;

   assign arready = !never_ready && (ar_wait >= ar_dly[araddr[4:2]]);
   assign rvalid  = s_pend && (r_cnt == 0);
   assign rdata   = s_pend ? sdata[s_idx] : 32'h0;
   assign rresp   = sresp[s_idx];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ar_wait <= 0;
         s_pend  <= 1'b0;
         s_idx   <= 3'd0;
         r_cnt   <= 0;
      end else begin
         if (s_pend) begin
            if (rvalid && rready) s_pend <= 1'b0;
            else if (r_cnt != 0)  r_cnt  <= r_cnt - 1;
         end
         if (arvalid && arready) begin
            s_pend  <= 1'b1;
            s_idx   <= araddr[4:2];
            r_cnt   <= r_dly[araddr[4:2]] - 1;
            ar_wait <= 0;
         end else if (arvalid) begin
            ar_wait <= ar_wait + 1;
         end else begin
            ar_wait <= 0;
         end
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      bit               ok;
      logic [2:0]       eidx;
      logic [4:0][31:0] rev;
      int               lat;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   issue_cyc = 0;
   int   done_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   initial begin : monitor
      logic        busy_q, done_q, arv_q, arr_q;
      logic [4:0]  addr_q;
      exp_t        e;
      busy_q = 1'b0; done_q = 1'b0; arv_q = 1'b0; arr_q = 1'b0; addr_q = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            busy_q = 1'b0; done_q = 1'b0; arv_q = 1'b0;
         end else begin
            chk("arvalid_rready_excl", 32'(arvalid & rready), 32'd0);
            if (s_pend) chk("rready_while_pending", 32'(rready), 32'd1);
            if (arv_q && !arr_q && arvalid) chk("araddr_hold", 32'(araddr), 32'(addr_q));
            if (done_q) chk("done_one_cycle", 32'(done), 32'd0);
            if (done) done_cnt++;
            if (busy_q && !busy) begin
               if (sb.size() == 0) begin
                  chk("unexpected_completion", 32'd1, 32'd0);
               end else begin
                  e = sb.pop_front();
                  chk("done", 32'(done), 32'(e.ok));
                  chk("error", 32'(error), 32'(!e.ok));
                  if (!e.ok) chk("err_index", 32'(err_index), 32'(e.eidx));
                  chk("valid", 32'(valid), 32'd1);
                  chk("arvalid_idle", 32'(arvalid), 32'd0);
                  chk("rev_major", rev_major, e.rev[0]);
                  chk("rev_minor", rev_minor, e.rev[1]);
                  chk("rev_build", rev_build, e.rev[2]);
                  chk("rev_rcand", rev_rcand, e.rev[3]);
                  chk("rev_date",  rev_date,  e.rev[4]);
                  chk("latency", 32'(cyc - issue_cyc), 32'(e.lat));
               end
            end
            busy_q = busy; done_q = done;
            arv_q = arvalid; arr_q = arready; addr_q = araddr;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic set_data(input logic [31:0] a, b, c, d, f);
      sdata[0] = a; sdata[1] = b; sdata[2] = c; sdata[3] = d; sdata[4] = f;
   endtask

   task automatic set_timing(input int ard, input int rd);
      for (int i = 0; i < 8; i++) begin
         ar_dly[i] = ard; r_dly[i] = rd; sresp[i] = RESP_OKAY;
      end
   endtask

   task automatic push(input bit ok, input logic [2:0] eidx, input logic [31:0] a, b, c, d, f,
                       input int lat);
      exp_t e;
      e.ok = ok; e.eidx = eidx; e.lat = lat;
      e.rev[0] = a; e.rev[1] = b; e.rev[2] = c; e.rev[3] = d; e.rev[4] = f;
      sb.push_back(e);
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      issue_cyc = cyc;
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((sb.size() != 0 || busy) && n < 200) begin
         @(negedge clk); n++;
      end
      if (n >= 200) chk({name, "_drain_timeout"}, 32'd1, 32'd0);
      repeat (2) @(negedge clk);
   endtask

   localparam logic [31:0] B0 = 32'hA000_0011, B1 = 32'hA000_0022, B2 = 32'hA000_0033,
                           B3 = 32'hA000_0044, B4 = 32'hA000_0055;

   initial begin : stim
      int n;
      // Reset state with the revision-slave timing and the auto-start data set
      set_timing(0, 2);
      set_data(32'd1, 32'd2, 32'd37, 32'd0, 32'h071A_07E6);
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_arvalid", 32'(arvalid), 32'd0);
      chk("rst_rready", 32'(rready), 32'd0);
      chk("rst_araddr", 32'(araddr), 32'd0);
      chk("rst_err_index", 32'(err_index), 32'd0);
      chk("rst_rev_date", rev_date, 32'd0);
      chk("arprot", 32'(arprot), 32'd0);

      // 1: auto-start after reset release, 16 cycles
      push(1'b1, 3'd0, 32'd1, 32'd2, 32'd37, 32'd0, 32'h071A_07E6, 16);
      rst_n = 1'b1;
      @(negedge clk); issue_cyc = cyc;
      wait_drain("autostart");

      // 2: backpressure on index 2 (ARREADY low 5 cycles, RVALID 7 cycles)
      set_data(B0, B1, B2, B3, B4);
      ar_dly[2] = 5; r_dly[2] = 7;
      push(1'b1, 3'd0, B0, B1, B2, B3, B4, 26);
      pulse_start();
      wait_drain("backpressure");
      set_timing(0, 2);

      // 3: SLVERR on index 3; previous snapshot must survive
      set_data(32'hC1, 32'hC2, 32'hC3, 32'hC4, 32'hC5);
      sresp[3] = RESP_SLVERR;
      push(1'b0, 3'd3, B0, B1, B2, B3, B4, 13);
      pulse_start();
      wait_drain("slverr");
      set_timing(0, 2);

      // 4: timeout, ARREADY never asserted (TIMEOUT_CYCLES=16)
      never_ready = 1'b1;
      push(1'b0, 3'd0, B0, B1, B2, B3, B4, 17);
      pulse_start();
      wait_drain("timeout");
      never_ready = 1'b0;

      // 5: zero-wait slave, start pulsed on the third busy cycle is ignored
      set_timing(0, 1);
      set_data(32'hD1, 32'hD2, 32'hD3, 32'hD4, 32'hD5);
      push(1'b1, 3'd0, 32'hD1, 32'hD2, 32'hD3, 32'hD4, 32'hD5, 11);
      pulse_start();
      chk("error_cleared_by_start", 32'(error), 32'd0);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      wait_drain("ignored_start");
      set_data(32'hE1, 32'hE2, 32'hE3, 32'hE4, 32'hE5);
      push(1'b1, 3'd0, 32'hE1, 32'hE2, 32'hE3, 32'hE4, 32'hE5, 11);
      pulse_start();
      wait_drain("next_start");

      // 6: reset during DATA of index 2, then clean auto refetch
      set_timing(0, 2);
      set_data(32'hF1, 32'hF2, 32'hF3, 32'hF4, 32'hF5);
      pulse_start();
      n = 0;
      while (!(s_pend && s_idx == 3'd2) && n < 100) begin
         @(negedge clk); n++;
      end
      if (n >= 100) chk("reach_data_idx2", 32'd0, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_busy", 32'(busy), 32'd0);
      chk("async_rst_valid", 32'(valid), 32'd0);
      chk("async_rst_rready", 32'(rready), 32'd0);
      chk("async_rst_arvalid", 32'(arvalid), 32'd0);
      chk("async_rst_rev_major", rev_major, 32'd0);
      chk("async_rst_rev_date", rev_date, 32'd0);
      @(negedge clk);
      set_data(32'h61, 32'h62, 32'h63, 32'h64, 32'h65);
      push(1'b1, 3'd0, 32'h61, 32'h62, 32'h63, 32'h64, 32'h65, 16);
      rst_n = 1'b1;
      @(negedge clk); issue_cyc = cyc;
      wait_drain("refetch");

      chk("done_pulses", 32'(done_cnt), 32'd5);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/axi_revision_fetch.md
# axi_revision_fetch

AXI4-Lite read master that sits directly upstream of the revision-register slave. After reset, or on request, it reads the five revision words (major, minor, build, release-candidate, date) and presents them as stable parallel outputs for status logic and the front-panel/telemetry path. A snapshot is committed only when all five reads complete with OKAY.

## Interface
Parameters:
- M_AXI_ADDR_WIDTH, 5, width of ARADDR
- M_AXI_DATA_WIDTH, 32, data width; only 32 is supported
- BASE_ADDR, 0, byte address of the major-revision register in the slave's space
- AUTO_START, 1, if 1, one fetch launches automatically after reset is released
- TIMEOUT_CYCLES, 1024, maximum cycles a single transaction may wait (AR plus R phase)

Ports:
- AXI_ACLK  in  1  clock
- AXI_ARESETN  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that requests a fetch
- busy  out  1  high while a fetch is in progress
- done  out  1  one-cycle pulse when a fetch commits successfully
- error  out  1  sticky; set on SLVERR, DECERR or timeout; cleared by the next start
- err_index  out  3  register index (0–4) that failed
- valid  out  1  high once at least one snapshot has been committed
- rev_major, rev_minor, rev_build, rev_rcand, rev_date  out  32 each  committed snapshot
- M_AXI_ARADDR  out  M_AXI_ADDR_WIDTH  read address
- M_AXI_ARVALID  out  1
- M_AXI_ARPROT  out  3  constant 3'b000
- M_AXI_ARREADY  in  1
- M_AXI_RDATA  in  32
- M_AXI_RRESP  in  2
- M_AXI_RVALID  in  1
- M_AXI_RREADY  out  1

## Operation
- Reset values: busy, done, error, valid, ARVALID and RREADY are 0; err_index and ARADDR are 0; all rev_* outputs are 0.
- FSM states:
  - IDLE: on start, or on the first cycle after reset when AUTO_START=1, set index=0, clear error, go to ADDR.
  - ADDR: ARVALID=1, ARADDR = BASE_ADDR + 4·index. On ARVALID&ARREADY, drop ARVALID and go to DATA.
  - DATA: RREADY=1. On RVALID, check RRESP:
    - OKAY: write RDATA into shadow[index]. If index==4, go to COMMIT; otherwise increment index and go to ADDR.
    - Any other response: go to FAIL.
  - COMMIT: copy shadow[0..4] to the rev_* outputs, set valid=1, pulse done, return to IDLE.
  - FAIL: set error=1 and err_index=index. The rev_* outputs and valid are left unchanged. Return to IDLE.
- Timeout counter:
  - Cleared on entry to ADDR.
  - Counts while in ADDR or DATA.
  - Reaching TIMEOUT_CYCLES-1 goes to FAIL. If ARVALID is still asserted at that point, it is dropped anyway.
- Only one transaction is outstanding at a time. ARVALID and RREADY are never high in the same cycle.
- start received while busy is ignored and is not queued.
- ARADDR and ARVALID are register outputs. Once ARVALID is asserted, ARADDR holds until the AR handshake.
- busy = (state != IDLE).

## Timing
- start is registered at edge N; ARVALID rises after edge N.
- Against a zero-wait slave (ARREADY=1, RVALID one cycle after AR), each register takes 2 cycles. Full fetch: start → done in 11 cycles.
- Against the revision slave (ARREADY idles high, RVALID two cycles after AR), each register takes 3 cycles. Full fetch: 16 cycles.
- The rev_* outputs and valid update on the same edge that raises done.
- RVALID arriving in the same cycle RREADY first rises is accepted in that cycle.
- Asynchronous reset mid-fetch:
  - All outputs return to their reset values immediately.
  - AUTO_START relaunches a fetch after release.
  - The slave may still hold RVALID afterwards; in the first DATA state it is consumed as the first response. This is acceptable only because the slave is reset on the same reset net.

## Structure
- Shared package holds:
  - State encoding: IDLE, ADDR, DATA, COMMIT, FAIL.
  - RRESP constants: OKAY=0, SLVERR=2.
  - Register indices: MAJOR=0, MINOR=1, BUILD=2, RCAND=3, DATE=4. The revision slave uses the same indices.
- Single module; no sub-module is needed. The timeout counter stays inline.

## Test plan
- Auto-start: slave model returns 1, 2, 37, 0, 0x07_1A_07E6. Required: done pulses once, valid=1, rev_date=0x071A07E6, busy low 16 cycles after reset release with the revision-slave timing.
- Backpressure: ARREADY held low 5 cycles, RVALID delayed 7 cycles on index 2. Required: ARADDR holds 0x08 throughout, RREADY stays high, results are correct.
- SLVERR on index 3 on the second fetch. Required: error=1, err_index=3, rev_* keep the first fetch's values, valid stays 1, done does not pulse.
- Timeout with TIMEOUT_CYCLES=16 and ARREADY never asserted. Required: error=1, err_index=0 at cycle 17, ARVALID=0, busy=0.
- start pulsed at the third cycle of a busy fetch. Required: it is ignored, exactly one done pulse, and the next start works.
- Reset asserted during DATA of index 2. Required: outputs go to 0 asynchronously, then a clean refetch completes.
